// File: rtl/seg_scan_decoder_if.sv
// Multiplexed seven-segment display bus: active-low segment and anode lines.
// The scanner drives this bus as master and the decoder observes it as slave.
interface seg_scan_decoder_if;
    logic [6:0] seg;
    logic [7:0] an;

    modport master (output seg, output an);
    modport slave  (input  seg, input  an);
endinterface

// File: rtl/seg_scan_decoder.sv
// Rebuilds the six BCD digits shown on the scanned 8-anode display and checks the scan.
// Optional SEG_DEC_ERR_CNT_EN adds a saturating fault counter output err_cnt.
module seg_scan_decoder (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_decoder_if.slave   bus,
    output logic [3:0]          uni,
    output logic [3:0]          dec,
    output logic [3:0]          cent,
    output logic [3:0]          unir,
    output logic [3:0]          decr,
    output logic [3:0]          centr,
    output logic                frame_valid,
    output logic                locked,
    output logic                err,
    output logic [1:0]          err_code
`ifdef SEG_DEC_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [6:0] DASH_PAT = 7'b0111111;

    // Returns {valid, digit}; the "X" glyph decodes to 4'hE.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1000000: res = {1'b1, 4'd0};
            7'b1111001: res = {1'b1, 4'd1};
            7'b0100100: res = {1'b1, 4'd2};
            7'b0110000: res = {1'b1, 4'd3};
            7'b0011001: res = {1'b1, 4'd4};
            7'b0010010: res = {1'b1, 4'd5};
            7'b0000010: res = {1'b1, 4'd6};
            7'b1111000: res = {1'b1, 4'd7};
            7'b0000000: res = {1'b1, 4'd8};
            7'b0010000: res = {1'b1, 4'd9};
            7'b0001001: res = {1'b1, 4'hE};
            default:    res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    logic [6:0] seg_q_r;
    logic [7:0] an_q_r;
    state_t     state_r, next_state_s;
    logic [2:0] exp_r, exp_nxt_s;
    logic [2:0] prev_r, prev_nxt_s;
    logic [3:0] shadow_r [0:6];

    logic [2:0] zero_cnt_s;
    logic [2:0] pos_s;
    logic       blank_s, pos_ok_s, pat_bad_s;
    logic [4:0] dec_s;
    logic       store_s, publish_s, fault_s;
    logic [1:0] code_s;

    // Classify the registered sample: blank, single position, or multi-anode.
    always_comb begin
        zero_cnt_s = 3'd0;
        pos_s      = 3'd0;
        for (int k = 0; k < 7; k++) begin
            zero_cnt_s = zero_cnt_s + {2'b00, ~an_q_r[k]};
            pos_s      = an_q_r[k] ? pos_s : 3'(k);
        end
        blank_s   = (an_q_r == 8'hFF);
        pos_ok_s  = an_q_r[7] && (zero_cnt_s == 3'd1);
        dec_s     = decode_seg(seg_q_r);
        pat_bad_s = (pos_s == 3'd3) ? (seg_q_r != DASH_PAT) : ~dec_s[4];
    end

    // Next-state and action decode; faults always fall back to IDLE.
    always_comb begin
        next_state_s = state_r;
        exp_nxt_s    = exp_r;
        prev_nxt_s   = prev_r;
        store_s      = 1'b0;
        publish_s    = 1'b0;
        fault_s      = 1'b0;
        code_s       = 2'd0;
        if (!blank_s && !pos_ok_s) begin
            fault_s      = 1'b1;
            code_s       = 2'd2;
            next_state_s = IDLE;
            exp_nxt_s    = 3'd0;
        end else if (blank_s) begin
            next_state_s = IDLE;
            exp_nxt_s    = 3'd0;
        end else if (pat_bad_s) begin
            fault_s      = 1'b1;
            code_s       = 2'd1;
            next_state_s = IDLE;
            exp_nxt_s    = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pos_s == 3'd0) begin
                        store_s      = 1'b1;
                        exp_nxt_s    = 3'd1;
                        prev_nxt_s   = 3'd0;
                        next_state_s = SCAN;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SCAN: begin
                    if (pos_s == prev_r) begin
                        store_s = 1'b1;
                    end else if (pos_s == exp_r) begin
                        store_s    = 1'b1;
                        prev_nxt_s = pos_s;
                        if (pos_s == 3'd6) begin
                            publish_s = 1'b1;
                            exp_nxt_s = 3'd0;
                        end else begin
                            exp_nxt_s = exp_r + 3'd1;
                        end
                    end else begin
                        fault_s      = 1'b1;
                        code_s       = 2'd3;
                        next_state_s = IDLE;
                        exp_nxt_s    = 3'd0;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    exp_nxt_s    = 3'd0;
                end
            endcase
        end
    end

    // State, input capture, shadow digits and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q_r     <= 7'h7F;
            an_q_r      <= 8'hFF;
            state_r     <= IDLE;
            exp_r       <= 3'd0;
            prev_r      <= 3'd0;
            for (int i = 0; i < 7; i++) shadow_r[i] <= 4'd0;
            uni         <= 4'd0;
            dec         <= 4'd0;
            cent        <= 4'd0;
            unir        <= 4'd0;
            decr        <= 4'd0;
            centr       <= 4'd0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
`ifdef SEG_DEC_ERR_CNT_EN
            err_cnt     <= 8'd0;
`endif
        end else begin
            seg_q_r     <= bus.seg;
            an_q_r      <= bus.an;
            state_r     <= next_state_s;
            exp_r       <= exp_nxt_s;
            prev_r      <= prev_nxt_s;
            frame_valid <= publish_s;
            err         <= fault_s;
            if (store_s && (pos_s != 3'd3)) shadow_r[pos_s] <= dec_s[3:0];
            // Position 6 arrives with the publish, so it bypasses the shadow.
            if (publish_s) begin
                uni   <= shadow_r[0];
                dec   <= shadow_r[1];
                cent  <= shadow_r[2];
                unir  <= shadow_r[4];
                decr  <= shadow_r[5];
                centr <= dec_s[3:0];
            end
            if (fault_s) err_code <= code_s;
`ifdef SEG_DEC_ERR_CNT_EN
            if (fault_s && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
`endif
        end
    end

    assign locked = (state_r == SCAN);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: per-cycle reference model plus directed literal checks.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] uni, dec, cent, unir, decr, centr;
    logic       frame_valid, locked, err;
    logic [1:0] err_code;
`ifdef SEG_DEC_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    seg_scan_decoder_if bus ();

    seg_scan_decoder dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .uni(uni), .dec(dec), .cent(cent), .unir(unir), .decr(decr), .centr(centr),
        .frame_valid(frame_valid), .locked(locked), .err(err), .err_code(err_code)
`ifdef SEG_DEC_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Glyph table: entries 0..9 are digits, entry 10 is the "X" glyph (value 14).
    logic [6:0] pat_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000, 7'b0001001};
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [7:0] BLANK = 8'hFF;

    // Reference model state
    logic [6:0] m_seg_d;
    logic [7:0] m_an_d;
    bit         m_track;
    int         m_next, m_last;
    int         m_buf [0:6];
    int         m_out [0:6];
    bit         m_fv, m_err;
    int         m_code;
    int         m_cnt;

    function automatic int glyph_value(input logic [6:0] s);
        for (int i = 0; i < 11; i++)
            if (pat_tab[i] == s) return (i == 10) ? 14 : i;
        return -1;
    endfunction

    function automatic logic [7:0] an_of(input int p);
        logic [7:0] v;
        v = 8'hFF;
        v[p] = 1'b0;
        return v;
    endfunction

    task automatic model_fault(input int c);
        m_err   = 1'b1;
        m_code  = c;
        m_track = 1'b0;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_step();
        int zeros, pos, d;
        bit ok;
        if (!rst_n) begin
            m_seg_d = 7'h7F; m_an_d = 8'hFF;
            m_track = 1'b0; m_next = 0; m_last = 0;
            for (int i = 0; i < 7; i++) begin m_buf[i] = 0; m_out[i] = 0; end
            m_fv = 1'b0; m_err = 1'b0; m_code = 0; m_cnt = 0;
            return;
        end
        m_fv = 1'b0; m_err = 1'b0;
        zeros = 0; pos = 0;
        for (int k = 0; k < 7; k++) if (!m_an_d[k]) begin zeros++; pos = k; end
        if (m_an_d == BLANK) begin
            m_track = 1'b0;
        end else if (!(m_an_d[7] && zeros == 1)) begin
            model_fault(2);
        end else begin
            d  = glyph_value(m_seg_d);
            ok = (pos == 3) ? (m_seg_d == DASH) : (d >= 0);
            if (!ok) model_fault(1);
            else if (!m_track) begin
                if (pos == 0) begin m_track = 1'b1; m_buf[0] = d; m_last = 0; m_next = 1; end
            end else if (pos == m_last) begin
                if (pos != 3) m_buf[pos] = d;
            end else if (pos == m_next) begin
                if (pos != 3) m_buf[pos] = d;
                m_last = pos;
                if (pos == 6) begin
                    for (int i = 0; i < 7; i++) m_out[i] = m_buf[i];
                    m_fv = 1'b1;
                    m_next = 0;
                end else m_next = pos + 1;
            end else model_fault(3);
        end
        m_seg_d = bus.seg;
        m_an_d  = bus.an;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge and full-output compare just after it.
    initial begin
        logic [35:0] act_v, exp_v;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            act_v = {uni, dec, cent, unir, decr, centr, frame_valid, locked, err, err_code};
            exp_v = {4'(m_out[0]), 4'(m_out[1]), 4'(m_out[2]), 4'(m_out[4]), 4'(m_out[5]),
                     4'(m_out[6]), m_fv, m_track, m_err, 2'(m_code)};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle: got %h, expected %h at %0t", act_v, exp_v, $time);
            end
`ifdef SEG_DEC_ERR_CNT_EN
            n_cmp++;
            if (err_cnt !== 8'(m_cnt)) begin
                n_bad++;
                $display("FAIL model_err_cnt: got %0d, expected %0d at %0t", err_cnt, m_cnt, $time);
            end
`endif
        end
    end

    task automatic drive(input logic [7:0] a, input logic [6:0] s);
        bus.an  = a;
        bus.seg = s;
        @(posedge clk);
        #1;
    endtask

    // Drives positions 0..6; digit values index pat_tab, position 3 always shows a dash.
    task automatic drive_frame(input int d0, input int d1, input int d2,
                               input int d4, input int d5, input int d6);
        int dv [0:6];
        dv = '{d0, d1, d2, 0, d4, d5, d6};
        for (int p = 0; p < 7; p++) drive(an_of(p), (p == 3) ? DASH : pat_tab[dv[p]]);
    endtask

    initial begin
        int ptr, last_pos, r, p;
        logic [7:0] a, last_an;
        logic [6:0] s, last_seg;

        rst_n   = 1'b0;
        bus.an  = 8'($urandom);
        bus.seg = 7'($urandom);
        for (int i = 0; i < 3; i++) begin
            bus.an = 8'($urandom); bus.seg = 7'($urandom);
            @(posedge clk); #1;
        end
        chk("reset_locked", locked, 0);
        chk("reset_err", err, 0);
        chk("reset_fv", frame_valid, 0);
        chk("reset_code", err_code, 0);
        chk("reset_digits", {uni, dec, cent, unir, decr, centr}, 0);
        rst_n = 1'b1;

        // Clean scan twice: 5,4,1,-,0,9,2
        drive(an_of(0), pat_tab[5]);
        drive(an_of(1), pat_tab[4]);
        chk("locked_after_pos0", locked, 1);
        for (int p2 = 2; p2 < 7; p2++)
            drive(an_of(p2), (p2 == 3) ? DASH : pat_tab[(p2 == 2) ? 1 : (p2 == 4) ? 0 : (p2 == 5) ? 9 : 2]);
        drive(an_of(0), pat_tab[5]);
        chk("frame1_valid", frame_valid, 1);
        chk("frame1_digits", {uni, dec, cent, unir, decr, centr}, 24'h541092);
        for (int p2 = 1; p2 < 7; p2++)
            drive(an_of(p2), (p2 == 3) ? DASH : pat_tab[(p2 == 1) ? 4 : (p2 == 2) ? 1 : (p2 == 4) ? 0 : (p2 == 5) ? 9 : 2]);
        drive(BLANK, 7'h7F);
        chk("frame2_valid", frame_valid, 1);
        drive(BLANK, 7'h7F);
        chk("frame2_fv_pulse", frame_valid, 0);
        chk("blank_unlocks", locked, 0);

        // Order fault 0,1,2,4
        drive(an_of(0), pat_tab[1]);
        drive(an_of(1), pat_tab[1]);
        drive(an_of(2), pat_tab[1]);
        drive(an_of(4), pat_tab[1]);
        drive(BLANK, 7'h7F);
        chk("order_err", err, 1);
        chk("order_code", err_code, 3);
        chk("order_locked", locked, 0);
        chk("order_hold", {uni, dec, cent, unir, decr, centr}, 24'h541092);
        drive_frame(3, 7, 8, 6, 1, 0);
        drive(BLANK, 7'h7F);
        chk("recover_digits", {uni, dec, cent, unir, decr, centr}, 24'h378610);

        // Wrong glyph at position 3
        drive(an_of(0), pat_tab[2]);
        drive(an_of(1), pat_tab[2]);
        drive(an_of(2), pat_tab[2]);
        drive(an_of(3), 7'b1000000);
        drive(BLANK, 7'h7F);
        chk("dash_err", err, 1);
        chk("dash_code", err_code, 1);

        // X glyph is a legal digit
        drive_frame(2, 3, 10, 4, 5, 6);
        drive(BLANK, 7'h7F);
        chk("x_frame_valid", frame_valid, 1);
        chk("x_cent", cent, 4'hE);
        chk("x_no_err", err, 0);

        // Blank mid-frame, then multi-anode fault
        drive(an_of(0), pat_tab[9]);
        drive(an_of(1), pat_tab[9]);
        drive(BLANK, 7'h7F);
        drive(BLANK, 7'h7F);
        chk("midblank_locked", locked, 0);
        chk("midblank_err", err, 0);
        chk("midblank_hold", cent, 4'hE);
        drive(8'b11111100, pat_tab[0]);
        drive(BLANK, 7'h7F);
        chk("multi_err", err, 1);
        chk("multi_code", err_code, 2);

        // Randomised traffic: mostly in-order scans with holds, blanks, faults and resets.
        ptr = 0; last_pos = -1; last_an = BLANK; last_seg = 7'h7F;
        for (int c = 0; c < 4000; c++) begin
            rst_n = 1'b1;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                a = an_of(ptr); s = (ptr == 3) ? DASH : pat_tab[$urandom_range(0, 10)];
                last_pos = ptr; ptr = (ptr + 1) % 7;
            end else if (r < 82) begin
                a = last_an;
                s = (last_pos >= 0 && last_pos != 3) ? pat_tab[$urandom_range(0, 10)] : last_seg;
            end else if (r < 86) begin
                a = BLANK; s = 7'($urandom); ptr = 0; last_pos = -1;
            end else if (r < 90) begin
                p = $urandom_range(0, 6);
                a = an_of(p); s = (p == 3) ? DASH : pat_tab[$urandom_range(0, 9)];
                last_pos = p; ptr = (p + 1) % 7;
            end else if (r < 94) begin
                a = an_of(ptr); s = 7'($urandom); last_pos = ptr; ptr = 0;
            end else if (r < 98) begin
                a = 8'($urandom); s = 7'($urandom); last_pos = -1; ptr = 0;
            end else begin
                a = 8'($urandom); s = 7'($urandom); rst_n = 1'b0; last_pos = -1; ptr = 0;
            end
            last_an = a; last_seg = s;
            drive(a, s);
        end
        rst_n = 1'b1;

`ifdef SEG_DEC_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(8'h00, 7'h7F);
            drive(BLANK, 7'h7F);
        end
        drive(BLANK, 7'h7F);
        chk("err_cnt_saturate", err_cnt, 8'hFF);
`endif
        drive(BLANK, 7'h7F);
        drive(BLANK, 7'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
